// File: rtl/regfile_pkg.sv
// Shared definitions for the 1-write / N-read register file.
package regfile_pkg;

    // Clear-engine state encoding.
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    // Read/write collision modes.
    localparam int FWD_OLD = 0;  // colliding read returns the pre-write word
    localparam int FWD_NEW = 1;  // colliding read returns the merged post-write word

    // Ceiling log2, used to size address fields at elaboration time.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/regfile_rdport.sv
// One registered read port: range check, optional write-forwarding,
// zero-load while the array is being cleared, and hold when not enabled.
module regfile_rdport
    import regfile_pkg::*;
#(
    parameter int WIDTH = 17,
    parameter int DEPTH = 4,
    parameter int AW    = 2,
    parameter int FWD   = FWD_OLD
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    input  logic [WIDTH-1:0] rf [DEPTH],
    input  logic             we_ok,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wmask,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] q
);

    localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

    logic             in_range;
    logic             collide;
    logic [WIDTH-1:0] word;
    logic [WIDTH-1:0] rd_word;

    assign in_range = ({1'b0, raddr} < DEPTH_W);
    assign word     = rf[raddr];
    assign collide  = we_ok && (raddr == waddr);

    // Select the stored word, or the merged write result when forwarding a collision.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        rd_word = word;
        if ((FWD == FWD_NEW) && collide) begin
            rd_word = (word & ~wmask) | (din & wmask);
        end
    end

    // Output register: cleared on reset, loads on re, holds otherwise.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            q <= '0;
        end else if (re) begin
            if (clear || !in_range) begin
                q <= '0;
            end else begin
                q <= rd_word;
            end
        end
    end

endmodule

// File: rtl/regfile_1wnr.sv
// Flop-based register file with one masked write port, NRD registered read
// ports and a post-reset clear engine that zeroes the array one entry per cycle.
module regfile_1wnr
    import regfile_pkg::*;
#(
    parameter int   WIDTH = 17,
    parameter int   DEPTH = 4,
    parameter int   NRD   = 2,
    parameter int   FWD   = FWD_OLD,
    parameter int   CLR   = 1,
    localparam int  AW    = (clog2(DEPTH) < 1) ? 1 : clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 we,
    input  logic [AW-1:0]        waddr,
    input  logic [WIDTH-1:0]     wmask,
    input  logic [WIDTH-1:0]     din,
    input  logic [NRD-1:0]       re,
    input  logic [NRD*AW-1:0]    raddr,
    output logic [NRD*WIDTH-1:0] q,
    output logic                 busy
);

    localparam logic [AW:0]   DEPTH_W   = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] CPTR_LAST = AW'(DEPTH - 1);

    logic [WIDTH-1:0] rf [DEPTH];

    state_t           state_q;
    state_t           state_d;
    logic [AW-1:0]    cptr_q;
    logic [AW-1:0]    cptr_d;
    logic             clearing;
    logic             we_ok;
    logic [WIDTH-1:0] wr_word;

    // busy comes straight from the state flop, so it has no input-to-output path.
    assign clearing = (state_q == ST_CLEAR);
    assign busy     = clearing;
    assign we_ok    = we && !clearing && !reset && ({1'b0, waddr} < DEPTH_W);
    assign wr_word  = (rf[waddr] & ~wmask) | (din & wmask);

    // Clear-engine state and pointer registers; reset restarts the sweep from entry 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= (CLR != 0) ? ST_CLEAR : ST_IDLE;
            cptr_q  <= '0;
        end else begin
            state_q <= state_d;
            cptr_q  <= cptr_d;
        end
    end

    // Next-state: walk cptr through every entry, then return to normal operation.
    always_comb begin
        state_d = state_q;
        cptr_d  = cptr_q;
        case (state_q)
            ST_CLEAR: begin
                if (cptr_q == CPTR_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    cptr_d = cptr_q + AW'(1);
                end
            end
            default: ;
        endcase
    end

    // Array update: the clear sweep has priority, user writes only when accepted.
    always_ff @(posedge clk) begin
        // NOTE: the array itself has no reset; the clear engine zeroes it so entries stay plain flops.
        if (!reset && clearing) begin
            rf[cptr_q] <= '0;
        end else if (we_ok) begin
            rf[waddr] <= wr_word;
        end
    end

    for (genvar i = 0; i < NRD; i++) begin : g_rd
        regfile_rdport #(
            .WIDTH (WIDTH),
            .DEPTH (DEPTH),
            .AW    (AW),
            .FWD   (FWD)
        ) u_rdport (
            .clk   (clk),
            .reset (reset),
            .clear (clearing),
            .re    (re[i]),
            .raddr (raddr[i*AW +: AW]),
            .rf    (rf),
            .we_ok (we_ok),
            .waddr (waddr),
            .wmask (wmask),
            .din   (din),
            .q     (q[i*WIDTH +: WIDTH])
        );
    end

endmodule

// File: tb/tb_regfile_1wnr.sv
// Directed bench for regfile_1wnr: four instances cover old/new collision
// modes, a non-power-of-two depth with three ports, and a reset mid-clear.
module tb_regfile_1wnr;

    logic clk;

    // Shared stimulus for u_a (FWD=0) and u_b (FWD=1): WIDTH 17, DEPTH 4, NRD 2.
    logic        rst_ab;
    logic        we_ab;
    logic [1:0]  waddr_ab;
    logic [16:0] wmask_ab;
    logic [16:0] din_ab;
    logic [1:0]  re_ab;
    logic [3:0]  raddr_ab;
    logic [33:0] q_a;
    logic [33:0] q_b;
    logic        busy_a;
    logic        busy_b;

    // u_c: DEPTH 5, NRD 3.
    logic        rst_c;
    logic        we_c;
    logic [2:0]  waddr_c;
    logic [16:0] wmask_c;
    logic [16:0] din_c;
    logic [2:0]  re_c;
    logic [8:0]  raddr_c;
    logic [50:0] q_c;
    logic        busy_c;

    // u_d: DEPTH 8, NRD 1.
    logic        rst_d;
    logic        we_d;
    logic [2:0]  waddr_d;
    logic [16:0] wmask_d;
    logic [16:0] din_d;
    logic        re_d;
    logic [2:0]  raddr_d;
    logic [16:0] q_d;
    logic        busy_d;

    int n_tests;
    int n_fail;

    regfile_1wnr #(.WIDTH(17), .DEPTH(4), .NRD(2), .FWD(0), .CLR(1)) u_a (
        .clk(clk), .reset(rst_ab), .we(we_ab), .waddr(waddr_ab), .wmask(wmask_ab),
        .din(din_ab), .re(re_ab), .raddr(raddr_ab), .q(q_a), .busy(busy_a)
    );

    regfile_1wnr #(.WIDTH(17), .DEPTH(4), .NRD(2), .FWD(1), .CLR(1)) u_b (
        .clk(clk), .reset(rst_ab), .we(we_ab), .waddr(waddr_ab), .wmask(wmask_ab),
        .din(din_ab), .re(re_ab), .raddr(raddr_ab), .q(q_b), .busy(busy_b)
    );

    regfile_1wnr #(.WIDTH(17), .DEPTH(5), .NRD(3), .FWD(0), .CLR(1)) u_c (
        .clk(clk), .reset(rst_c), .we(we_c), .waddr(waddr_c), .wmask(wmask_c),
        .din(din_c), .re(re_c), .raddr(raddr_c), .q(q_c), .busy(busy_c)
    );

    regfile_1wnr #(.WIDTH(17), .DEPTH(8), .NRD(1), .FWD(0), .CLR(1)) u_d (
        .clk(clk), .reset(rst_d), .we(we_d), .waddr(waddr_d), .wmask(wmask_d),
        .din(din_d), .re(re_d), .raddr(raddr_d), .q(q_d), .busy(busy_d)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [16:0] obs, input logic [16:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        n_tests = 0;
        n_fail  = 0;

        rst_ab = 1'b1; we_ab = 1'b0; waddr_ab = '0; wmask_ab = '1; din_ab = '0; re_ab = '0; raddr_ab = '0;
        rst_c  = 1'b1; we_c  = 1'b0; waddr_c  = '0; wmask_c  = '1; din_c  = '0; re_c  = '0; raddr_c  = '0;
        rst_d  = 1'b1; we_d  = 1'b0; waddr_d  = '0; wmask_d  = '1; din_d  = '0; re_d  = 1'b0; raddr_d = '0;

        // ---------------- reset and clear sweep (all instances) ----------------
        tick();
        tick();
        check("rst_busy_a", 17'(busy_a), 17'h1);
        check("rst_busy_d", 17'(busy_d), 17'h1);
        check("rst_q_a0", q_a[16:0], 17'h0);
        check("rst_q_b1", q_b[33:17], 17'h0);

        // Hold a full write to addr 0 through the clear; it must be dropped.
        rst_ab = 1'b0; rst_c = 1'b0; rst_d = 1'b0;
        we_ab = 1'b1; waddr_ab = 2'd0; din_ab = 17'h1FFFF; re_ab = 2'b11; raddr_ab = 4'h0;
        we_c  = 1'b1; waddr_c  = 3'd0; din_c  = 17'h1FFFF;
        for (int k = 1; k <= 8; k++) begin
            tick();
            check($sformatf("clr_busy_a_%0d", k), 17'(busy_a), 17'(k < 4));
            check($sformatf("clr_busy_b_%0d", k), 17'(busy_b), 17'(k < 4));
            check($sformatf("clr_busy_c_%0d", k), 17'(busy_c), 17'(k < 5));
            check($sformatf("clr_busy_d_%0d", k), 17'(busy_d), 17'(k < 8));
            check($sformatf("clr_q_a0_%0d", k), q_a[16:0], 17'h0);
            check($sformatf("clr_q_b1_%0d", k), q_b[33:17], 17'h0);
            if (k == 4) begin
                we_ab = 1'b0;
            end
            if (k == 5) begin
                we_c = 1'b0;
            end
        end

        // All four entries read zero after the clear.
        for (int a = 0; a < 4; a++) begin
            raddr_ab = {2'(a), 2'(a)};
            tick();
            check($sformatf("clr_rd_a_%0d", a), q_a[16:0], 17'h0);
            check($sformatf("clr_rd_b_%0d", a), q_b[33:17], 17'h0);
        end

        // ---------------- basic write / dual read / hold ----------------
        we_ab = 1'b1; waddr_ab = 2'd2; din_ab = 17'h0ABCD; wmask_ab = 17'h1FFFF; re_ab = 2'b00;
        tick();
        we_ab = 1'b0; re_ab = 2'b11; raddr_ab = {2'd2, 2'd2};
        tick();
        check("basic_a_q0", q_a[16:0],  17'h0ABCD);
        check("basic_a_q1", q_a[33:17], 17'h0ABCD);
        check("basic_b_q0", q_b[16:0],  17'h0ABCD);
        check("basic_b_q1", q_b[33:17], 17'h0ABCD);
        re_ab = 2'b01; raddr_ab = {2'd0, 2'd2};
        tick();
        check("hold_a_q1", q_a[33:17], 17'h0ABCD);
        check("hold_b_q1", q_b[33:17], 17'h0ABCD);

        // ---------------- masked write ----------------
        we_ab = 1'b1; waddr_ab = 2'd1; din_ab = 17'h1FFFF; wmask_ab = 17'h1FFFF; re_ab = 2'b00;
        tick();
        din_ab = 17'h0; wmask_ab = 17'h000FF;
        tick();
        we_ab = 1'b0; re_ab = 2'b01; raddr_ab = {2'd0, 2'd1};
        tick();
        check("mask_a_q0", q_a[16:0], 17'h1FF00);
        check("mask_b_q0", q_b[16:0], 17'h1FF00);
        check("mask_a_q1_hold", q_a[33:17], 17'h0ABCD);

        // ---------------- single-port collision ----------------
        we_ab = 1'b1; waddr_ab = 2'd3; din_ab = 17'h00001; wmask_ab = 17'h1FFFF; re_ab = 2'b00;
        tick();
        din_ab = 17'h00002; re_ab = 2'b01; raddr_ab = {2'd0, 2'd3};
        tick();
        check("coll_old_q0", q_a[16:0], 17'h00001);
        check("coll_new_q0", q_b[16:0], 17'h00002);
        we_ab = 1'b0;
        tick();
        check("coll_old_next_q0", q_a[16:0], 17'h00002);
        check("coll_new_next_q0", q_b[16:0], 17'h00002);

        // ---------------- two ports colliding with a partial-mask write ----------------
        we_ab = 1'b1; waddr_ab = 2'd3; din_ab = 17'h10000; wmask_ab = 17'h10000;
        re_ab = 2'b11; raddr_ab = {2'd3, 2'd3};
        tick();
        check("coll2_old_q0", q_a[16:0],  17'h00002);
        check("coll2_old_q1", q_a[33:17], 17'h00002);
        check("coll2_new_q0", q_b[16:0],  17'h10002);
        check("coll2_new_q1", q_b[33:17], 17'h10002);
        we_ab = 1'b0;
        tick();
        check("coll2_old_next_q1", q_a[33:17], 17'h10002);

        // ---------------- DEPTH=5, three ports ----------------
        we_c = 1'b1; wmask_c = 17'h1FFFF; waddr_c = 3'd0; din_c = 17'h00011;
        tick();
        waddr_c = 3'd4; din_c = 17'h12345;
        tick();
        waddr_c = 3'd6; din_c = 17'h1F0F0;
        tick();
        we_c = 1'b0; re_c = 3'b111; raddr_c = {3'd4, 3'd4, 3'd0};
        tick();
        check("np2_p0_addr0", q_c[16:0],  17'h00011);
        check("np2_p1_addr4", q_c[33:17], 17'h12345);
        check("np2_p2_addr4", q_c[50:34], 17'h12345);
        re_c = 3'b011; raddr_c = {3'd0, 3'd6, 3'd6};
        tick();
        check("np2_p0_addr6", q_c[16:0],  17'h0);
        check("np2_p1_addr6", q_c[33:17], 17'h0);
        check("np2_p2_hold",  q_c[50:34], 17'h12345);
        re_c = 3'b111; raddr_c = {3'd3, 3'd2, 3'd1};
        tick();
        check("np2_p0_addr1", q_c[16:0],  17'h0);
        check("np2_p1_addr2", q_c[33:17], 17'h0);
        check("np2_p2_addr3", q_c[50:34], 17'h0);

        // ---------------- DEPTH=8: fill, reset, reset again mid-clear ----------------
        we_d = 1'b1; wmask_d = 17'h1FFFF;
        for (int a = 0; a < 8; a++) begin
            waddr_d = 3'(a);
            din_d   = 17'h1F000 | 17'(a);
            tick();
        end
        we_d = 1'b0; re_d = 1'b1; raddr_d = 3'd7;
        tick();
        check("fill_d_addr7", q_d, 17'h1F007);
        re_d = 1'b0;
        rst_d = 1'b1;
        tick();
        rst_d = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
        end
        check("midclr_busy_before", 17'(busy_d), 17'h1);
        rst_d = 1'b1;
        tick();
        check("midclr_busy_rst", 17'(busy_d), 17'h1);
        rst_d = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            tick();
            check($sformatf("midclr_busy_%0d", k), 17'(busy_d), 17'(k < 8));
        end
        re_d = 1'b1;
        for (int a = 0; a < 8; a++) begin
            raddr_d = 3'(a);
            tick();
            check($sformatf("midclr_rd_%0d", a), q_d, 17'h0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
